// File: rtl/frame_streamer.sv
// Raster-order frame reader: pulls WIDTH x HEIGHT pixels from a synchronous-read memory and
// streams them one per transfer with sof/eol/eof tags, using an output register plus a skid slot.
module frame_streamer #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned WIDTH     = 28,
   parameter int unsigned HEIGHT    = 28,
   parameter int unsigned ADDR_BITS = 10,
   parameter int unsigned ROW_GAP   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] base_addr,
   output logic                 mem_rd_en,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic [DATA_BITS-1:0] mem_rd_data,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 sof,
   output logic                 eol,
   output logic                 eof,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned ColW = $clog2(WIDTH);
   localparam int unsigned RowW = $clog2(HEIGHT);
   localparam int unsigned GapW = $clog2(ROW_GAP + 2);

   localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT - 1);
   // Never compared when ROW_GAP is zero, since StGap is then unreachable.
   localparam logic [GapW-1:0] GapLast = GapW'(ROW_GAP - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StGap,
      StDrain,
      StDone
   } state_e;

   typedef struct packed {
      logic                 sof;
      logic                 eol;
      logic                 eof;
      logic [DATA_BITS-1:0] data;
   } pix_t;

   state_e               state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [RowW-1:0]      row_q, row_d;
   logic [ColW-1:0]      col_q, col_d;
   logic [GapW-1:0]      gap_q, gap_d;

   logic                 rd_pend_q, rd_pend_d;
   logic [2:0]           rd_tag_q, rd_tag_d;
   pix_t                 out_q, out_d;
   logic                 out_vld_q, out_vld_d;
   pix_t                 skid_q, skid_d;
   logic                 skid_vld_q, skid_vld_d;

   logic                 xfer;
   logic [1:0]           occ;
   logic                 credit_ok;
   pix_t                 ret;

   // Occupancy counts the read in flight plus both buffer slots; a read is only issued when
   // the returning pixel is guaranteed a free slot.
   always_comb begin
      xfer      = out_vld_q & data_ready;
      occ       = 2'(rd_pend_q) + 2'(out_vld_q) + 2'(skid_vld_q);
      credit_ok = (occ < 2'd2) || ((occ == 2'd2) && xfer);
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      row_d     = row_q;
      col_d     = col_q;
      gap_d     = gap_q;
      mem_rd_en = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               addr_d  = base_addr;
               row_d   = '0;
               col_d   = '0;
            end
         end
         StRun: begin
            if (credit_ok) begin
               mem_rd_en = 1'b1;
               addr_d    = addr_q + ADDR_BITS'(1);
               if (col_q == ColLast) begin
                  col_d = '0;
                  if (row_q == RowLast) begin
                     state_d = StDrain;
                  end else begin
                     row_d = row_q + RowW'(1);
                     if (ROW_GAP != 0) begin
                        state_d = StGap;
                        gap_d   = '0;
                     end
                  end
               end else begin
                  col_d = col_q + ColW'(1);
               end
            end
         end
         StGap: begin
            if (gap_q == GapLast) begin
               state_d = StRun;
            end else begin
               gap_d = gap_q + GapW'(1);
            end
         end
         StDrain: begin
            if (!rd_pend_q && !skid_vld_q && (!out_vld_q || xfer)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Tags travel alongside the read so they line up with the returning data.
   always_comb begin
      rd_pend_d = mem_rd_en;
      rd_tag_d  = rd_tag_q;
      if (mem_rd_en) begin
         rd_tag_d = {(row_q == '0) && (col_q == '0),
                     col_q == ColLast,
                     (row_q == RowLast) && (col_q == ColLast)};
      end

      ret.sof  = rd_tag_q[2];
      ret.eol  = rd_tag_q[1];
      ret.eof  = rd_tag_q[0];
      ret.data = mem_rd_data;

      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;

      if (!out_vld_q || xfer) begin
         if (skid_vld_q) begin
            // Skid drains first so pixel order is preserved.
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = rd_pend_q;
            if (rd_pend_q) begin
               skid_d = ret;
            end
         end else begin
            out_vld_d = rd_pend_q;
            if (rd_pend_q) begin
               out_d = ret;
            end
         end
      end else if (rd_pend_q) begin
         skid_d     = ret;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         gap_q      <= '0;
         rd_pend_q  <= 1'b0;
         rd_tag_q   <= '0;
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         row_q      <= row_d;
         col_q      <= col_d;
         gap_q      <= gap_d;
         rd_pend_q  <= rd_pend_d;
         rd_tag_q   <= rd_tag_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   always_comb begin
      mem_addr   = addr_q;
      data_out   = out_q.data;
      data_valid = out_vld_q;
      sof        = out_vld_q & out_q.sof;
      eol        = out_vld_q & out_q.eol;
      eof        = out_vld_q & out_q.eof;
      busy       = (state_q == StRun) || (state_q == StGap) || (state_q == StDrain);
      done       = (state_q == StDone);
   end

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: default 28x28 instance under several ready patterns and bases,
// plus a small 4x3 instance with row gaps; pixels are predicted from their raster index.
module tb_frame_streamer;

   localparam int NPIX = 784;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       start_a, rd_en_a, valid_a, ready_a, sof_a, eol_a, eof_a, busy_a, done_a;
   logic [9:0] base_a, addr_a;
   logic [7:0] rdata_a, dout_a;

   logic       start_b, rd_en_b, valid_b, ready_b, sof_b, eol_b, eof_b, busy_b, done_b;
   logic [9:0] base_b, addr_b;
   logic [7:0] rdata_b, dout_b;

   int n_checks = 0;
   int n_fail   = 0;

   frame_streamer u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .start       (start_a),
      .base_addr   (base_a),
      .mem_rd_en   (rd_en_a),
      .mem_addr    (addr_a),
      .mem_rd_data (rdata_a),
      .data_out    (dout_a),
      .data_valid  (valid_a),
      .data_ready  (ready_a),
      .sof         (sof_a),
      .eol         (eol_a),
      .eof         (eof_a),
      .busy        (busy_a),
      .done        (done_a)
   );

   frame_streamer #(
      .WIDTH   (4),
      .HEIGHT  (3),
      .ROW_GAP (2)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .start       (start_b),
      .base_addr   (base_b),
      .mem_rd_en   (rd_en_b),
      .mem_addr    (addr_b),
      .mem_rd_data (rdata_b),
      .data_out    (dout_b),
      .data_valid  (valid_b),
      .data_ready  (ready_b),
      .sof         (sof_b),
      .eol         (eol_b),
      .eof         (eof_b),
      .busy        (busy_b),
      .done        (done_b)
   );

   // Memory content at each address is its low byte.
   always @(posedge clk) begin
      if (rd_en_a) rdata_a <= addr_a[7:0];
      if (rd_en_b) rdata_b <= addr_b[7:0];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // mode 0: ready always high; 1: random ready plus a mid-frame start pulse;
   // 2: ready low for the 10 cycles starting at the first valid cycle.
   task automatic run_frame(input int base, input int mode, input int exp_done);
      int         idx, reads, eof_cycle, done_cycle;
      bit         prev_stall, seen_valid;
      logic [11:0] prev_out;
      idx = 0; reads = 0; eof_cycle = -1; done_cycle = -1;
      prev_stall = 1'b0; seen_valid = 1'b0; prev_out = '0;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         start_a = (c == 0) || (mode == 1 && c == 200);
         base_a  = (c == 0) ? 10'(base) : 10'd5;
         case (mode)
            0:       ready_a = 1'b1;
            1:       ready_a = 1'($urandom_range(0, 1));
            default: ready_a = !(c >= 3 && c < 13);
         endcase
         @(negedge clk);
         check_eq("credit_limit", 32'((reads - idx) <= 2), 1);
         if (rd_en_a) begin
            check_eq("addr", addr_a, (base + reads) % 1024);
            reads++;
         end
         if (valid_a && !seen_valid) begin
            seen_valid = 1'b1;
            check_eq("first_valid_cycle", c, 3);
         end
         if (mode != 1 && c >= 3 && idx < NPIX) check_eq("no_gap", valid_a, 1);
         if (prev_stall) check_eq("hold", {valid_a, dout_a, sof_a, eol_a, eof_a}, prev_out);
         if (mode == 2 && c == 12) check_eq("reads_in_stall", reads, 2);
         check_eq("done", done_a, eof_cycle >= 0 && c == eof_cycle + 1);
         check_eq("busy", busy_a, c >= 1 && !(eof_cycle >= 0 && c > eof_cycle));
         if (done_a && done_cycle < 0) done_cycle = c;
         if (valid_a && ready_a) begin
            check_eq("data", dout_a, ((base + idx) % 1024) & 255);
            check_eq("tags", {sof_a, eol_a, eof_a},
                     {idx == 0, (idx % 28) == 27, idx == NPIX - 1});
            if (idx == NPIX - 1) eof_cycle = c;
            idx++;
         end
         prev_stall = valid_a && !ready_a;
         prev_out   = {valid_a, dout_a, sof_a, eol_a, eof_a};
         if (eof_cycle >= 0 && c == eof_cycle + 1) break;
      end
      start_a = 1'b0;
      check_eq("frame_complete", idx, NPIX);
      if (exp_done >= 0) check_eq("done_cycle", done_cycle, exp_done);
      @(posedge clk); #1;
      ready_a = 1'b1;
      @(negedge clk);
      check_eq("busy_after", busy_a, 0);
      check_eq("done_one_cycle", done_a, 0);
   endtask

   task automatic run_small();
      bit exp_v;
      int exp_i;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         start_b = (c == 0);
         base_b  = 10'd0;
         ready_b = 1'b1;
         @(negedge clk);
         exp_v = 1'b0;
         exp_i = 0;
         // Pixel i of a 4-wide row appears 2 extra cycles later per completed row.
         for (int i = 0; i < 12; i++) begin
            if (3 + i + 2 * (i / 4) == c) begin
               exp_v = 1'b1;
               exp_i = i;
            end
         end
         check_eq("gap_valid", valid_b, exp_v);
         if (exp_v) begin
            check_eq("gap_data", dout_b, exp_i);
            check_eq("gap_tags", {sof_b, eol_b, eof_b},
                     {exp_i == 0, (exp_i % 4) == 3, exp_i == 11});
         end
         check_eq("gap_done", done_b, c == 19);
      end
      start_b = 1'b0;
   endtask

   task automatic reset_mid_frame();
      for (int c = 0; c < 104; c++) begin
         @(posedge clk); #1;
         start_a = (c == 0);
         base_a  = 10'd0;
         ready_a = 1'b1;
         rst     = (c == 103);
         @(negedge clk);
      end
      start_a = 1'b0;
      check_eq("pre_rst_pixel", dout_a, 100);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_rd", {rd_en_a, addr_a}, 0);
      check_eq("rst_out", {dout_a, valid_a, sof_a, eol_a, eof_a}, 0);
      check_eq("rst_status", {busy_a, done_a}, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_eq("rst_quiet", {valid_a, done_a, rd_en_a}, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      start_a = 1'b0; base_a = '0; ready_a = 1'b1;
      start_b = 1'b0; base_b = '0; ready_b = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("reset_a_rd", {rd_en_a, addr_a}, 0);
      check_eq("reset_a_out", {dout_a, valid_a, sof_a, eol_a, eof_a}, 0);
      check_eq("reset_a_status", {busy_a, done_a}, 0);
      check_eq("reset_b", {rd_en_b, valid_b, busy_b, done_b}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_frame(0, 0, 787);
      run_small();
      run_frame(0, 1, -1);
      run_frame(0, 1, -1);
      run_frame(1020, 0, 787);
      run_frame(0, 2, 797);
      reset_mid_frame();
      run_frame(0, 0, 787);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_streamer.md
# frame_streamer

Reads a WIDTH×HEIGHT image from a synchronous-read memory in raster order and emits it as a one-pixel-per-cycle stream (`data_out`/`data_valid`) with frame/line markers. It is the producer feeding the 5×5 window line buffer and later conv stages. It honours downstream backpressure, and tying `data_ready` high gives the gap-free stream the line buffer expects.

## Interface
- `DATA_BITS`, 8, pixel width
- `WIDTH`, 28, pixels per row (≥2)
- `HEIGHT`, 28, rows per frame (≥2)
- `ADDR_BITS`, 10, memory address width
- `ROW_GAP`, 0, idle cycles inserted between the last read of a row and the first read of the next row
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a frame; sampled only in IDLE
- `base_addr`  in  ADDR_BITS  address of pixel (0,0); captured when `start` is accepted
- `mem_rd_en`  out  1  read strobe
- `mem_addr`  out  ADDR_BITS  read address
- `mem_rd_data`  in  DATA_BITS  read data, valid exactly 1 cycle after `mem_rd_en`
- `data_out`  out  DATA_BITS  pixel
- `data_valid`  out  1  pixel valid
- `data_ready`  in  1  downstream accepts; transfer = `data_valid && data_ready`
- `sof`, `eol`, `eof`  out  1 each  qualified by `data_valid`: first pixel, last pixel of row, last pixel of frame
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at frame completion

## Operation
- FSM states: IDLE, RUN, GAP, DRAIN, DONE.
- IDLE: `start`=1 → capture `base_addr`, clear read row/col counters → RUN.
- RUN: issue a read when the credit check passes: (in-flight read + output reg occupied + skid reg occupied) < 2, or == 2 with a transfer this cycle. Address = base + row·WIDTH + col, modulo 2^ADDR_BITS. Advance col; at col WIDTH-1 wrap to 0 and increment row.
- After the last read of a row (row < HEIGHT-1): if ROW_GAP>0 → GAP for exactly ROW_GAP cycles with no reads, then RUN. If ROW_GAP=0, stay in RUN.
- After read of pixel (HEIGHT-1, WIDTH-1) → DRAIN. No further reads.
- DRAIN: wait until the in-flight read has returned and the output and skid registers are empty (eof pixel transferred) → DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Returned data plus its sof/eol/eof tags go to the output register if that is empty or transferring this cycle. Otherwise they go to the skid register. The skid register refills the output register ahead of new data, so order is preserved.
- While `data_valid`=1 and `data_ready`=0, `data_out`/markers hold stable. No pixel is dropped or duplicated.
- `start` outside IDLE is ignored.
- `rst` mid-frame: return to IDLE, flush both registers, discard the in-flight read, and raise no `done`.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `data_out`=0, `data_valid`=0, `sof`=`eol`=`eof`=0, `busy`=0, `done`=0.
- `mem_rd_en`/`mem_addr` are combinational from state/counters/credits.
- `start` high at cycle 0 → RUN in cycle 1, first read in cycle 1, `data_valid` first high in cycle 3. Pipeline latency read→valid is 2 cycles.
- With `data_ready`=1 and ROW_GAP=0, `data_valid` is continuously high for WIDTH·HEIGHT cycles.
- `busy` is high from cycle 1 through the cycle before `done`. `done` rises the cycle after the eof transfer.
- Next `start` is accepted in the cycle after `done`.
- Total with ready=1: done at cycle 3 + WIDTH·HEIGHT + (HEIGHT-1)·ROW_GAP.

## Test plan
- Defaults, memory preloaded with addr[7:0], base 0, ready=1, start at cycle 0:
  - first valid at cycle 3, data 0, sof=1;
  - 784 consecutive transfers, eol on every 28th pixel;
  - eof with data 783[7:0];
  - `done` at cycle 787, busy low afterwards.
- ROW_GAP=2, WIDTH=4, HEIGHT=3:
  - 2 idle valid cycles after each eol except the last;
  - done at cycle 3+12+4=19.
- Random `data_ready` (50%), WIDTH=HEIGHT=28:
  - sequence 0..783 exactly once and in order;
  - data held stable under stall;
  - credits never exceed 2, with no overwrite.
- base_addr=1020, ADDR_BITS=10: addresses wrap 1020,1021,1022,1023,0,1,…
- `start` pulsed mid-frame is ignored (no restart). `rst` at pixel 100 returns all outputs to reset values next cycle. A new start then produces a full frame beginning with sof.
- ready=0 from first valid for 10 cycles: exactly 2 reads issued, then none. Data 0 is held. After release, 0,1,2… stream without gaps.
